// File: rtl/sprint1_dl_pkg.sv
// sprint1_dl_pkg -- shared types and constants for the Sprint 1 ROM download
// sequencer: FSM state encoding, ROM region map and region index constants.
package sprint1_dl_pkg;

  typedef enum logic [2:0] {
    WAIT_DL,
    LOADING,
    SETTLE,
    RUN,
    ERROR
  } dl_state_e;

  // Region indices double as bit positions in the one-hot rom_we strobe.
  localparam int NUM_REGIONS = 4;
  localparam int PROG        = 0;
  localparam int CHAR        = 1;
  localparam int MOTION      = 2;
  localparam int SYNC        = 3;

  // Absolute download addresses; ROM_END is the first out-of-range byte.
  localparam logic [24:0] PROG_BASE   = 25'h0000;
  localparam logic [24:0] CHAR_BASE   = 25'h2000;
  localparam logic [24:0] MOTION_BASE = 25'h2800;
  localparam logic [24:0] SYNC_BASE   = 25'h3000;
  localparam logic [24:0] ROM_END     = 25'h3100;

  // Byte counters must hold size+1 (8193) so an overlong region is visible.
  localparam int CNT_W = 14;

  localparam logic [CNT_W-1:0] PROG_SIZE   = 14'd8192;
  localparam logic [CNT_W-1:0] CHAR_SIZE   = 14'd2048;
  localparam logic [CNT_W-1:0] MOTION_SIZE = 14'd2048;
  localparam logic [CNT_W-1:0] SYNC_SIZE   = 14'd256;

  function automatic logic [CNT_W-1:0] region_size(input int idx);
    case (idx)
      PROG:    return PROG_SIZE;
      CHAR:    return CHAR_SIZE;
      MOTION:  return MOTION_SIZE;
      SYNC:    return SYNC_SIZE;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dl_region_decode.sv
// dl_region_decode -- combinational decode of an absolute download address
// into a ROM region.
//   addr     in  25  absolute ioctl byte address
//   region   out  4  one-hot region (PROG, CHAR, MOTION, SYNC); 0 when out of range
//   rel_addr out 13  address relative to the region base; 0 when out of range
//   oor      out  1  address is at or above the end of the ROM map
module dl_region_decode
  import sprint1_dl_pkg::*;
(
  input  logic [24:0]            addr,
  output logic [NUM_REGIONS-1:0] region,
  output logic [12:0]            rel_addr,
  output logic                   oor
);

  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path leaves
    // one unassigned, which would otherwise infer a latch.
    region   = '0;
    rel_addr = '0;
    oor      = 1'b0;
    if (addr < CHAR_BASE) begin
      region[PROG] = 1'b1;
      rel_addr     = 13'(addr - PROG_BASE);
    end else if (addr < MOTION_BASE) begin
      region[CHAR] = 1'b1;
      rel_addr     = 13'(addr - CHAR_BASE);
    end else if (addr < SYNC_BASE) begin
      region[MOTION] = 1'b1;
      rel_addr       = 13'(addr - MOTION_BASE);
    end else if (addr < ROM_END) begin
      region[SYNC] = 1'b1;
      rel_addr     = 13'(addr - SYNC_BASE);
    end else begin
      oor = 1'b1;
    end
  end

endmodule

// File: rtl/sprint1_dl_ctrl.sv
// sprint1_dl_ctrl -- ROM download and core reset sequencer for Sprint 1.
// Routes ioctl download bytes to four ROM regions, validates that the load
// was complete and in range, and holds the core in reset until it was.
//   SETTLE_CYCLES          core_reset_n low time after a good load / reset_req
//   clk_sys        in   1  system clock
//   Reset_n        in   1  synchronous active-low reset
//   ioctl_download in   1  high while a download is in progress
//   ioctl_wr       in   1  byte write strobe
//   ioctl_addr     in  25  absolute byte address
//   ioctl_data     in   8  byte data
//   reset_req      in   1  OSD reset or user button
//   rom_addr       out 13  region-relative byte address
//   rom_data       out  8  byte data
//   rom_we         out  4  one-hot region write strobe (PROG, CHAR, MOTION, SYNC)
//   core_reset_n   out  1  active-low core reset
//   load_done      out  1  last download complete and in range
//   load_err       out  1  last download incomplete or out of range
//   checksum       out  8  mod-256 sum of the last download's ROM bytes
module sprint1_dl_ctrl
  import sprint1_dl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4096
) (
  input  logic        clk_sys,
  input  logic        Reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        reset_req,
  output logic [12:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [3:0]  rom_we,
  output logic        core_reset_n,
  output logic        load_done,
  output logic        load_err,
  output logic [7:0]  checksum
);

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  dl_state_e        state, state_next;
  logic             dl_q;
  logic [CNT_W-1:0] cnt      [NUM_REGIONS];
  logic [CNT_W-1:0] cnt_next [NUM_REGIONS];
  logic             oor_flag, oor_next;
  logic [7:0]       checksum_next;
  logic [15:0]      settle_cnt;

  logic [NUM_REGIONS-1:0] dec_region;
  logic [12:0]            dec_rel;
  logic                   dec_oor;

  logic dl_rise, load_ok, start_load, wr_accept;

  dl_region_decode u_decode (
    .addr     (ioctl_addr),
    .region   (dec_region),
    .rel_addr (dec_rel),
    .oor      (dec_oor)
  );

  assign dl_rise = ioctl_download & ~dl_q;

  always_comb begin
    load_ok = ~oor_flag;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cnt[i] != region_size(i)) load_ok = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      WAIT_DL: if (ioctl_download) state_next = LOADING;
      LOADING: if (!ioctl_download) state_next = load_ok ? SETTLE : ERROR;
      SETTLE: begin
        if (dl_rise)                               state_next = LOADING;
        else if (!reset_req && settle_cnt == '0)   state_next = RUN;
      end
      RUN: begin
        if (dl_rise)        state_next = LOADING;
        else if (reset_req) state_next = SETTLE;
      end
      ERROR:   if (dl_rise) state_next = LOADING;
      default: state_next = WAIT_DL;
    endcase
  end

  // A write in the same cycle as the download rise lands on top of the
  // LOADING-entry clear, so the clear and the increment are merged here.
  assign start_load = (state != LOADING) && (state_next == LOADING);
  assign wr_accept  = ioctl_wr && ioctl_download && ((state == LOADING) || start_load);

  always_comb begin
    oor_next      = start_load ? 1'b0 : oor_flag;
    checksum_next = start_load ? 8'h00 : checksum;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      cnt_next[i] = start_load ? '0 : cnt[i];
    end
    if (wr_accept) begin
      if (dec_oor) begin
        oor_next = 1'b1;
      end else begin
        checksum_next = checksum_next + ioctl_data;
        // Saturate at size+1 so duplicates can never wrap back to a pass.
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if (dec_region[i] && cnt_next[i] != region_size(i) + CNT_W'(1))
            cnt_next[i] = cnt_next[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!Reset_n) begin
      state        <= WAIT_DL;
      dl_q         <= 1'b0;
      // NOTE: the byte counters are reset even though LOADING clears them,
      // because load_ok reads them and must never see X.
      for (int i = 0; i < NUM_REGIONS; i++) cnt[i] <= '0;
      oor_flag     <= 1'b0;
      checksum     <= 8'h00;
      settle_cnt   <= '0;
      rom_we       <= '0;
      rom_addr     <= '0;
      rom_data     <= '0;
      core_reset_n <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state    <= state_next;
      dl_q     <= ioctl_download;
      cnt      <= cnt_next;
      oor_flag <= oor_next;
      checksum <= checksum_next;

      rom_we <= '0;
      if (wr_accept && !dec_oor) begin
        rom_we   <= dec_region;
        rom_addr <= dec_rel;
        rom_data <= ioctl_data;
      end

      if (start_load) begin
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end else if (state == LOADING && state_next == SETTLE) begin
        load_done <= 1'b1;
      end else if (state == LOADING && state_next == ERROR) begin
        load_err <= 1'b1;
      end

      if (state_next == SETTLE && (state != SETTLE || reset_req))
        settle_cnt <= SETTLE_LOAD;
      else if (state == SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 16'd1;

      // Reset asserts as soon as RUN is left, but is released only after RUN
      // has been held for one cycle: this gives SETTLE_CYCLES+1 cycles low.
      core_reset_n <= (state == RUN) && (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_sprint1_dl_ctrl.sv
// tb_sprint1_dl_ctrl -- self-checking bench for sprint1_dl_ctrl. Expected ROM
// strobes are queued when a write is driven and compared when rom_we fires.
module tb_sprint1_dl_ctrl;

  localparam int SETTLE = 4096;

  logic        clk_sys = 1'b0;
  logic        Reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        reset_req;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_we;
  logic        core_reset_n;
  logic        load_done;
  logic        load_err;
  logic [7:0]  checksum;

  typedef struct packed {
    logic [3:0]  we;
    logic [12:0] addr;
    logic [7:0]  data;
  } sb_item_t;

  sb_item_t   sb_q[$];
  int         n_asserts = 0;
  int         n_fail    = 0;
  int         strobes   = 0;
  logic [7:0] exp_sum   = 8'h00;
  logic       seen_high;

  always #5 clk_sys = ~clk_sys;

  sprint1_dl_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk_sys        (clk_sys),
    .Reset_n        (Reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .reset_req      (reset_req),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_we         (rom_we),
    .core_reset_n   (core_reset_n),
    .load_done      (load_done),
    .load_err       (load_err),
    .checksum       (checksum)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Reference region map.
  function automatic sb_item_t expect_write(input logic [24:0] a, input logic [7:0] d);
    sb_item_t it;
    it.we   = 4'b0000;
    it.addr = 13'h0;
    it.data = d;
    if (a <= 25'h1FFF)      begin it.we = 4'b0001; it.addr = a[12:0]; end
    else if (a <= 25'h27FF) begin it.we = 4'b0010; it.addr = 13'(a - 25'h2000); end
    else if (a <= 25'h2FFF) begin it.we = 4'b0100; it.addr = 13'(a - 25'h2800); end
    else if (a <= 25'h30FF) begin it.we = 4'b1000; it.addr = 13'(a - 25'h3000); end
    return it;
  endfunction

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    sb_item_t it;
    it         = expect_write(a, d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    if (it.we != 4'b0000) begin
      sb_q.push_back(it);
      exp_sum = exp_sum + d;
    end
    step();
  endtask

  // Raises download together with the first write; data = addr[7:0].
  task automatic load_range(input int first, input int last, input int skip);
    ioctl_download = 1'b1;
    exp_sum        = 8'h00;
    strobes        = 0;
    for (int a = first; a <= last; a++) begin
      if (a != skip) write_byte(25'(a), 8'(a));
    end
    ioctl_wr = 1'b0;
  endtask

  // Drops download with a write in the same cycle, which must be ignored.
  task automatic end_load();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h10;
    ioctl_data     = 8'h55;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_release(input string tag, input int expect_k);
    int k = 0;
    while (k < 2 * SETTLE + 8 && core_reset_n !== 1'b1) begin
      step();
      k++;
    end
    check(tag, k, expect_k);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_we"},       rom_we,       4'h0);
    check({tag, "_rom_addr"},     rom_addr,     13'h0);
    check({tag, "_rom_data"},     rom_data,     8'h00);
    check({tag, "_core_reset_n"}, core_reset_n, 1'b0);
    check({tag, "_load_done"},    load_done,    1'b0);
    check({tag, "_load_err"},     load_err,     1'b0);
    check({tag, "_checksum"},     checksum,     8'h00);
  endtask

  // Scoreboard: every strobe must match the oldest queued write.
  always @(negedge clk_sys) begin
    if (rom_we !== 4'b0000) begin
      sb_item_t exp_it;
      strobes++;
      check("sb_expected_strobe", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_it = sb_q.pop_front();
        check("sb_strobe", {rom_we, rom_addr, rom_data}, exp_it);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    reset_req      = 1'b0;
    repeat (3) step();
    check_reset_vals("por");
    Reset_n = 1'b1;
    step();
    check("wait_dl_core_reset_n", core_reset_n, 1'b0);

    // Full, clean load.
    load_range(0, 'h30FF, -1);
    end_load();
    check("full_load_done",     load_done,    1'b1);
    check("full_load_err",      load_err,     1'b0);
    check("full_checksum",      checksum,     8'h80);
    check("full_checksum_sum",  checksum,     exp_sum);
    check("full_core_reset_n",  core_reset_n, 1'b0);
    wait_release("load_release_cycles", SETTLE + 1);
    check("full_strobe_count",  strobes,      'h3100);
    check("full_sb_empty",      sb_q.size(),  0);

    // reset_req from RUN, then a second pulse mid-settle.
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    check("rr_assert_next_cycle", core_reset_n, 1'b0);
    wait_release("rr_release_cycles", SETTLE + 1);
    check("rr_load_done_kept", load_done, 1'b1);
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    seen_high = 1'b0;
    repeat (99) begin
      step();
      if (core_reset_n !== 1'b0) seen_high = 1'b1;
    end
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    wait_release("rr_extend_cycles", SETTLE + 1);
    check("rr_no_early_release", seen_high, 1'b0);

    // Incomplete load (0x30FF missing), started from RUN.
    load_range(0, 'h30FF, 'h30FF);
    end_load();
    check("omit_load_err",     load_err,     1'b1);
    check("omit_load_done",    load_done,    1'b0);
    check("omit_core_reset_n", core_reset_n, 1'b0);
    seen_high = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      reset_req = (i % 1000 == 500);
      step();
      if (core_reset_n !== 1'b0) seen_high = 1'b1;
    end
    reset_req = 1'b0;
    check("omit_held_in_reset", seen_high, 1'b0);
    check("omit_strobe_count",  strobes,   'h30FF);

    // Full load plus one out-of-range byte at 0x3100.
    load_range(0, 'h3100, -1);
    end_load();
    check("oor_load_err",  load_err,  1'b1);
    check("oor_load_done", load_done, 1'b0);
    check("oor_checksum",  checksum,  8'h80);
    step();
    check("oor_strobe_count", strobes,     'h3100);
    check("oor_sb_empty",     sb_q.size(), 0);

    // Region decode spot checks and strobe width.
    ioctl_download = 1'b1;
    exp_sum        = 8'h00;
    write_byte(25'h2805, 8'hA5);
    check("motion_rom_we",   rom_we,   4'b0100);
    check("motion_rom_addr", rom_addr, 13'h0005);
    check("motion_rom_data", rom_data, 8'hA5);
    write_byte(25'h1FFF, 8'h11);
    check("prog_last_we",    rom_we,   4'b0001);
    check("prog_last_addr",  rom_addr, 13'h1FFF);
    write_byte(25'h3000, 8'h22);
    check("sync_first_we",   rom_we,   4'b1000);
    check("sync_first_addr", rom_addr, 13'h0000);
    write_byte(25'h27FF, 8'h33);
    check("char_last_we",    rom_we,   4'b0010);
    check("char_last_addr",  rom_addr, 13'h07FF);
    ioctl_wr = 1'b0;
    step();
    check("strobe_one_cycle", rom_we, 4'b0000);
    end_load();
    check("short_load_err", load_err, 1'b1);
    check("short_checksum", checksum, exp_sum);

    // Reset halfway through a load, released with no new download.
    load_range(0, 'h0FFF, -1);
    Reset_n        = 1'b0;
    ioctl_download = 1'b0;
    step();
    step();
    check_reset_vals("midload_rst");
    Reset_n = 1'b1;
    step();
    check_reset_vals("after_rst");
    seen_high = 1'b0;
    for (int i = 0; i < 200; i++) begin
      reset_req = (i == 50);
      step();
      if (core_reset_n !== 1'b0) seen_high = 1'b1;
    end
    reset_req = 1'b0;
    check("after_rst_held", seen_high, 1'b0);
    check("after_rst_load_done", load_done, 1'b0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
